// File: rtl/apb_arbiter_rr.sv
// Round-robin arbiter that serialises APB transfers from several cores onto one
// downstream APB master port, with a watchdog for transfers nobody answers.
module apb_arbiter_rr #(
   parameter int unsigned BUS_WIDTH    = 16,
   parameter int unsigned MASTER_PORTS = 2,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
   input  logic [MASTER_PORTS-1:0]           S_PWRITE,
   input  logic [MASTER_PORTS-1:0]           S_PSELx,
   input  logic [MASTER_PORTS-1:0]           S_PENABLE,
   input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
   output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
   output logic [MASTER_PORTS-1:0]           S_PREADY,
   output logic [BUS_WIDTH-1:0]              M_PADDR,
   output logic                              M_PWRITE,
   output logic                              M_PSELx,
   output logic                              M_PENABLE,
   output logic [BUS_WIDTH-1:0]              M_PWDATA,
   input  logic [BUS_WIDTH-1:0]              M_PRDATA,
   input  logic                              M_PREADY,
   output logic                              timeout
);

   localparam int unsigned IW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t                   state;
   state_t                   next_state;
   logic [IW-1:0]            grant;
   logic [IW-1:0]            last;
   logic [IW-1:0]            winner;
   logic                     found;
   int unsigned              idx;
   logic [CW-1:0]            cnt;
   logic [BUS_WIDTH-1:0]     rdata;
   logic                     psel_d;
   logic                     penable_d;
   logic [MASTER_PORTS-1:0]  pready_d;
   logic                     timeout_d;

   // Core-side enable carries no information for this arbiter.
   logic unused_penable;
   assign unused_penable = ^S_PENABLE;

   logic [BUS_WIDTH-1:0] s_addr  [MASTER_PORTS];
   logic [BUS_WIDTH-1:0] s_wdata [MASTER_PORTS];

   for (genvar g = 0; g < MASTER_PORTS; g++) begin : g_slice
      assign s_addr[g]  = S_PADDR[g*BUS_WIDTH +: BUS_WIDTH];
      assign s_wdata[g] = S_PWDATA[g*BUS_WIDTH +: BUS_WIDTH];
   end

   // All cores see the same read-data register; only the granted core gets READY.
   assign S_PRDATA = {MASTER_PORTS{rdata}};

   // Round-robin search starting just after the last granted core.
   always_comb begin
      winner = last;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < MASTER_PORTS; k++) begin
         idx = (32'(last) + 32'd1 + k) % MASTER_PORTS;
         if (!found && S_PSELx[IW'(idx)]) begin
            winner = IW'(idx);
            found  = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; ACCESS ends on slave ready or on the last watchdog cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (found) next_state = SETUP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (M_PREADY || (cnt == CW'(TIMEOUT - 1))) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode, looking one state ahead so the bus signals come from flops.
   always_comb begin
      psel_d    = (next_state == SETUP) || (next_state == ACCESS);
      penable_d = (next_state == ACCESS);
      pready_d  = '0;
      timeout_d = 1'b0;
      if ((state == ACCESS) && (next_state == DONE)) begin
         pready_d[grant] = 1'b1;
         timeout_d       = !M_PREADY;
      end
   end

   // Registered outputs, request latch, round-robin pointer, watchdog and read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         M_PSELx   <= 1'b0;
         M_PENABLE <= 1'b0;
         M_PADDR   <= '0;
         M_PWRITE  <= 1'b0;
         M_PWDATA  <= '0;
         S_PREADY  <= '0;
         timeout   <= 1'b0;
         grant     <= '0;
         last      <= IW'(MASTER_PORTS - 1);
         cnt       <= '0;
         rdata     <= '0;
      end else begin
         M_PSELx   <= psel_d;
         M_PENABLE <= penable_d;
         S_PREADY  <= pready_d;
         timeout   <= timeout_d;
         if ((state == IDLE) && found) begin
            M_PADDR  <= s_addr[winner];
            M_PWRITE <= S_PWRITE[winner];
            M_PWDATA <= s_wdata[winner];
            grant    <= winner;
            last     <= winner;
         end
         if (next_state == SETUP) begin
            cnt <= '0;
         end else if ((state == ACCESS) && (next_state == ACCESS)) begin
            cnt <= cnt + CW'(1);
         end
         if (state == ACCESS) begin
            if (M_PREADY) begin
               rdata <= M_PRDATA;
            end else if (next_state == DONE) begin
               rdata <= '0;
            end
         end
      end
   end

endmodule
